// File: rtl/sb_config_loader.sv
// rtl/sb_config_loader.sv - Serial config frame loader with checksum-gated commit of the switch-box prog word
module sb_config_loader #(
    parameter int PROG_W = 32,
    parameter int CHK_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [PROG_W-1:0] prog,
    output logic              prog_valid,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(PROG_W) + 1;
    localparam int SLICES = PROG_W / CHK_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHK    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t            state;
    logic [PROG_W-1:0] shadow;
    logic [CHK_W-1:0]  rx_chk;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    function automatic logic [CHK_W-1:0] fold(input logic [PROG_W-1:0] w);
        logic [CHK_W-1:0] r;
        r = '0;
        for (int i = 0; i < SLICES; i++) begin
            r = r ^ w[i*CHK_W +: CHK_W];
        end
        return r;
    endfunction

    // Ready is a pure decode of the state register, never of cfg_valid.
    assign cfg_ready = (state == SHIFT) || (state == CHK);
    assign busy      = (state != IDLE);
    assign accept    = cfg_ready && cfg_valid && !cfg_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prog       <= '0;
            prog_valid <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            shadow     <= '0;
            rx_chk     <= '0;
            cnt        <= '0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT, CHK: begin
                    // A start mid-frame restarts the payload; the bit beside it is dropped.
                    if (cfg_start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else if (accept) begin
                        if (state == SHIFT) begin
                            shadow <= {shadow[PROG_W-2:0], cfg_bit};
                            if (cnt == CNT_W'(PROG_W - 1)) begin
                                state <= CHK;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            rx_chk <= {rx_chk[CHK_W-2:0], cfg_bit};
                            if (cnt == CNT_W'(CHK_W - 1)) begin
                                state <= COMMIT;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    if (fold(shadow) == rx_chk) begin
                        prog       <= shadow;
                        prog_valid <= 1'b1;
                        cfg_done   <= 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_config_loader.sv
// tb/tb_sb_config_loader.sv - Directed self-checking bench for sb_config_loader
module tb_sb_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        cfg_bit;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] prog;
    logic        prog_valid;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ready_low = 0;
    int stall_cycles = 0;

    sb_config_loader #(.PROG_W(32), .CHK_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .prog       (prog),
        .prog_valid (prog_valid),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents the first n bits of data MSB-first; during stalls an inverted bit is shown.
    task automatic send_bits(input logic [39:0] data, input int n, input bit rnd);
        int sent;
        int guard;
        logic [39:0] d;
        d = data;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 2000) begin
            cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_bit   = cfg_valid ? d[39] : ~d[39];
            if (cfg_ready !== 1'b1) ready_low++;
            tick();
            if (cfg_valid) begin
                d = d << 1;
                sent++;
            end else begin
                stall_cycles++;
            end
            guard++;
        end
        if (sent < n) ready_low++;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
        tick();
        tick();
        check("rst_prog", prog, 32'h0);
        check("rst_flags", {prog_valid, cfg_ready, cfg_done, cfg_err, busy}, 5'b0);
        rst = 1'b0;
        tick();
        check("idle_ready", {cfg_ready, busy}, 2'b00);

        // Good frame, valid held high
        start_pulse();
        check("start_busy", {cfg_ready, busy}, 2'b11);
        send_bits({32'hA5C30F96, 8'hFF}, 40, 1'b0);
        check("good_ready_40", ready_low, 0);
        check("commit_state", {cfg_ready, busy, cfg_done, prog_valid}, 4'b0100);
        check("prog_not_yet", prog, 32'h0);
        tick();
        check("good_prog", prog, 32'hA5C30F96);
        check("good_flags", {prog_valid, cfg_done, cfg_err, busy}, 4'b1100);
        tick();
        check("done_pulse", {cfg_done, cfg_err}, 2'b00);

        // Bad checksum keeps the old word
        start_pulse();
        send_bits({32'h12345678, 8'h00}, 40, 1'b0);
        tick();
        check("bad_err", {cfg_err, cfg_done}, 2'b10);
        check("bad_prog_kept", prog, 32'hA5C30F96);
        check("bad_valid_kept", prog_valid, 1'b1);
        tick();
        check("err_pulse", {cfg_err, cfg_done}, 2'b00);

        // Restart after 17 bits; bit beside the restart must be dropped
        start_pulse();
        send_bits({32'hDEADBEEF, 8'h00}, 17, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        check("restart_busy", {cfg_ready, busy}, 2'b11);
        send_bits({32'h0000FFFF, 8'h00}, 40, 1'b0);
        tick();
        check("restart_prog", prog, 32'h0000FFFF);
        check("restart_done", {cfg_done, cfg_err}, 2'b10);

        // Random stalls with inverted garbage bits
        ready_low = 0;
        start_pulse();
        send_bits({32'hA5C30F96, 8'hFF}, 40, 1'b1);
        tick();
        check("stall_ready", ready_low, 0);
        check("stall_prog", prog, 32'hA5C30F96);
        check("stall_done", {cfg_done, cfg_err}, 2'b10);
        tick();

        // Reset during the checksum phase
        start_pulse();
        send_bits({32'h0000FFFF, 8'h00}, 35, 1'b0);
        rst = 1'b1; cfg_valid = 1'b1;
        tick();
        rst = 1'b0; cfg_valid = 1'b0;
        check("midrst_prog", prog, 32'h0);
        check("midrst_flags", {prog_valid, busy, cfg_ready, cfg_done, cfg_err}, 5'b0);
        tick();
        tick();
        check("midrst_nopulse", {cfg_done, cfg_err, busy}, 3'b000);

        // Start during COMMIT is ignored
        start_pulse();
        send_bits({32'h12345678, 8'h08}, 40, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("commit_start_prog", prog, 32'h12345678);
        check("commit_start_done", {cfg_done, prog_valid}, 2'b11);
        check("commit_start_idle", {busy, cfg_ready}, 2'b00);
        tick();
        tick();
        check("idle_stays", {busy, cfg_ready, cfg_done}, 3'b000);
        cfg_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
